// File: rtl/wb_mux_n_wdt.sv
// Wishbone classic 1:N interconnect with address-window filter, decode-error
// response, per-transaction watchdog, master-abort handling and sticky fault IRQ.
module wb_mux_n_wdt #(
   parameter int                          N_SLAVES    = 4,
   parameter int                          ADDR_W      = 32,
   parameter int                          DATA_W      = 32,
   parameter logic [ADDR_W-1:0]           FILTER_MASK = 32'hff00_0000,
   parameter logic [ADDR_W-1:0]           FILTER_ADDR = 32'h3000_0000,
   parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_ADDR  = {N_SLAVES{32'h0}},
   parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_MASK  = {N_SLAVES{32'hffff_0000}},
   parameter int                          TIMEOUT     = 255
) (
   input  logic                            wb_clk_i,
   input  logic                            wb_rst_i,
   input  logic [ADDR_W-1:0]               wbm_adr_i,
   input  logic [DATA_W-1:0]               wbm_dat_i,
   input  logic [DATA_W/8-1:0]             wbm_sel_i,
   input  logic                            wbm_we_i,
   input  logic                            wbm_cyc_i,
   input  logic                            wbm_stb_i,
   output logic [DATA_W-1:0]               wbm_dat_o,
   output logic                            wbm_ack_o,
   output logic                            wbm_err_o,
   output logic                            wbm_rty_o,
   output logic [N_SLAVES*ADDR_W-1:0]      wbs_adr_o,
   output logic [N_SLAVES*DATA_W-1:0]      wbs_dat_o,
   output logic [N_SLAVES*DATA_W/8-1:0]    wbs_sel_o,
   output logic [N_SLAVES-1:0]             wbs_we_o,
   output logic [N_SLAVES-1:0]             wbs_cyc_o,
   output logic [N_SLAVES-1:0]             wbs_stb_o,
   input  logic [N_SLAVES*DATA_W-1:0]      wbs_dat_i,
   input  logic [N_SLAVES-1:0]             wbs_ack_i,
   input  logic [N_SLAVES-1:0]             wbs_err_i,
   input  logic [N_SLAVES-1:0]             wbs_rty_i,
   input  logic                            fault_clr_i,
   output logic                            fault_irq_o,
   output logic [1:0]                      fault_status_o
);
   localparam int SEL_W = DATA_W / 8;
   localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] dat;
      logic [SEL_W-1:0]  sel;
      logic              we;
   } req_t;

   state_t              state;
   req_t                req_r;
   logic [IDX_W-1:0]    idx;
   logic [N_SLAVES-1:0] cyc_oh;
   logic [WD_W-1:0]     wd;
   logic                rsp_ack, rsp_err, rsp_rty;
   logic [DATA_W-1:0]   rsp_dat;

   logic                hit;
   logic [IDX_W-1:0]    hit_idx;
   logic                term_busy, req;
   logic                s_ack, s_err, s_rty, s_any, wd_expired;
   logic [DATA_W-1:0]   s_dat;
   logic [1:0]          fault_set, fault_nxt;

   // Descending scan so the lowest matching index is the last assignment.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((wbm_adr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_ADDR[i*ADDR_W +: ADDR_W]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // While a termination pulse is out the master still presents the old request.
   assign term_busy  = wbm_ack_o | wbm_err_o | wbm_rty_o;
   assign req        = wbm_cyc_i & wbm_stb_i & ~term_busy &
                       ((wbm_adr_i & FILTER_MASK) == FILTER_ADDR);

   assign s_ack      = wbs_ack_i[idx];
   assign s_err      = wbs_err_i[idx];
   assign s_rty      = wbs_rty_i[idx];
   assign s_dat      = wbs_dat_i[idx*DATA_W +: DATA_W];
   assign s_any      = s_ack | s_err | s_rty;
   assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

   assign fault_set[0] = (state == IDLE) & req & ~hit;
   assign fault_set[1] = (state == ACTIVE) & wbm_cyc_i & ~s_any & wd_expired;
   assign fault_nxt    = (fault_status_o & ~{2{fault_clr_i}}) | fault_set;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state          <= IDLE;
         req_r          <= '0;
         idx            <= '0;
         cyc_oh         <= '0;
         wd             <= '0;
         rsp_ack        <= 1'b0;
         rsp_err        <= 1'b0;
         rsp_rty        <= 1'b0;
         rsp_dat        <= '0;
         wbm_ack_o      <= 1'b0;
         wbm_err_o      <= 1'b0;
         wbm_rty_o      <= 1'b0;
         wbm_dat_o      <= '0;
         fault_status_o <= 2'b00;
         fault_irq_o    <= 1'b0;
      end else begin
         wbm_ack_o      <= 1'b0;
         wbm_err_o      <= 1'b0;
         wbm_rty_o      <= 1'b0;
         fault_status_o <= fault_nxt;
         fault_irq_o    <= |fault_nxt;
         case (state)
            IDLE: begin
               if (req) begin
                  req_r.adr <= wbm_adr_i;
                  req_r.dat <= wbm_dat_i;
                  req_r.sel <= wbm_sel_i;
                  req_r.we  <= wbm_we_i;
                  if (hit) begin
                     idx    <= hit_idx;
                     cyc_oh <= N_SLAVES'(1) << hit_idx;
                     wd     <= '0;
                     state  <= ACTIVE;
                  end else begin
                     rsp_ack <= 1'b0;
                     rsp_err <= 1'b1;
                     rsp_rty <= 1'b0;
                     rsp_dat <= '0;
                     state   <= RESP;
                  end
               end
            end
            ACTIVE: begin
               if (!wbm_cyc_i) begin
                  cyc_oh <= '0;
                  state  <= IDLE;
               end else if (s_any) begin
                  cyc_oh  <= '0;
                  rsp_err <= s_err;
                  rsp_rty <= ~s_err & s_rty;
                  rsp_ack <= ~s_err & ~s_rty;
                  rsp_dat <= s_err ? '0 : s_dat;
                  state   <= RESP;
               end else if (wd_expired) begin
                  cyc_oh  <= '0;
                  rsp_ack <= 1'b0;
                  rsp_err <= 1'b1;
                  rsp_rty <= 1'b0;
                  rsp_dat <= '0;
                  state   <= RESP;
               end else begin
                  wd <= wd + WD_W'(1);
               end
            end
            RESP: begin
               wbm_ack_o <= rsp_ack;
               wbm_err_o <= rsp_err;
               wbm_rty_o <= rsp_rty;
               wbm_dat_o <= rsp_dat;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < N_SLAVES; g++) begin : g_port
      assign wbs_adr_o[g*ADDR_W +: ADDR_W] = req_r.adr;
      assign wbs_dat_o[g*DATA_W +: DATA_W] = req_r.dat;
      assign wbs_sel_o[g*SEL_W +: SEL_W]   = req_r.sel;
      assign wbs_we_o[g]                   = cyc_oh[g] & req_r.we;
   end
   assign wbs_cyc_o = cyc_oh;
   assign wbs_stb_o = cyc_oh;
endmodule
